bit_serializer: RTL



---
 rtl/bit_serializer_pkg.sv | 12 +
 rtl/bit_serializer_bit_counter.sv | 32 +++
 rtl/bit_serializer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer slice.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;

  localparam int SER_WIDTH_DEF = 8;

endpackage

// File: rtl/bit_serializer_bit_counter.sv
// Bit position counter for the serializer: clog2(WIDTH) bits, synchronous
// clear, increment enable, and a terminal flag at WIDTH-1.
module bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic terminal_o
);

  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)    count_d = '0;
    else if (inc_i) count_d = count_q + CW'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign terminal_o = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end, MSB first, idle line held at 0.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_SHIFT  = SHIFT;
`ifdef SERIALIZER_PARITY_EN
  localparam logic [1:0] S_PARITY = PARITY;
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             cnt_clear, cnt_inc, terminal;
  logic             accept;
`ifdef SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (cnt_clear),
    .inc_i      (cnt_inc),
    .terminal_o (terminal)
  );

  // Ready depends only on state and count so upstream never sees a loop.
`ifdef SERIALIZER_PARITY_EN
  assign data_ready = (state_q == S_IDLE) || (state_q == S_PARITY);
`else
  assign data_ready = (state_q == S_IDLE) || ((state_q == S_SHIFT) && terminal);
`endif
  assign accept = data_valid && data_ready;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      S_IDLE: ;
      S_SHIFT: begin
        if (!terminal) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          cnt_inc = 1'b1;
        end else begin
`ifdef SERIALIZER_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_IDLE;
`endif
          shift_d   = '0;
          cnt_clear = 1'b1;
        end
      end
`ifdef SERIALIZER_PARITY_EN
      S_PARITY: begin
        state_d   = S_IDLE;
        cnt_clear = 1'b1;
      end
`endif
      default: begin
        state_d   = S_IDLE;
        shift_d   = '0;
        cnt_clear = 1'b1;
      end
    endcase

    // A load at the last-bit cycle overrides the return to IDLE: gapless frames.
    if (accept) begin
      state_d   = S_SHIFT;
      shift_d   = data_in;
      cnt_clear = 1'b1;
      cnt_inc   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_d  = ^data_in;
`endif
    end
  end

  always_comb begin
    out_valid_d = (state_d != S_IDLE);
    out_bit_d   = 1'b0;
    if (state_d == S_SHIFT) out_bit_d = shift_d[WIDTH-1];
`ifdef SERIALIZER_PARITY_EN
    if (state_d == S_PARITY) out_bit_d = parity_d;
`endif
  end

  // NOTE: the shift register is reset along with control so no stale word
  // bits can reach the detector after a mid-frame reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef SERIALIZER_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
`endif

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);

endmodule
